video_effect_switch: RTL and testbench

VIDEO_EFFECT_SWITCH -- requirements
Module: video_effect_switch

---
 rtl/video_effect_switch_pkg.sv | 21 ++
 rtl/video_frame_tick.sv | 28 ++
 rtl/video_effect_switch.sv | 162 ++++++++++++++++
 tb/tb_video_effect_switch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_effect_switch_pkg.sv
// Shared types, default sizing and request validation for the video effect switch.
package video_effect_switch_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_DW          = 8;
  localparam int DEF_MUTE_FRAMES = 1;
  localparam int MAX_CH          = 32;
  localparam int FCNT_W          = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_MUTE    = 2'd2
  } state_e;

  // True when at most one request bit is set (all-zero means bypass).
  function automatic logic onehot0(input logic [MAX_CH-1:0] v);
    return ($countones(v) <= 1);
  endfunction

endpackage

// File: rtl/video_frame_tick.sv
// Detects the rising edge of vsync as the frame boundary and counts frames.
module video_frame_tick
  import video_effect_switch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vs_i,
  output logic              frame_tick_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);

  logic              vs_q;
  logic [FCNT_W-1:0] cnt_q;

  assign frame_tick_o = vs_i & ~vs_q;
  assign frame_cnt_o  = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      vs_q <= vs_i;
      if (frame_tick_o) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/video_effect_switch.sv
// Selects bypass or one effect channel, switching only at frame boundaries with
// optional muted frames, and pre-enables the target effect while waiting for vsync.
//
// state      | meaning
// RUN        | committed source streaming, no switch outstanding
// WAIT_VS    | target loaded in pending and enabled, waiting for a frame boundary
// MUTE       | new source committed, data blanked for MUTE_FRAMES boundaries
module video_effect_switch
  import video_effect_switch_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DW          = DEF_DW,
  parameter int MUTE_FRAMES = DEF_MUTE_FRAMES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init_over,
  input  logic                   vs_in,
  input  logic                   hs_in,
  input  logic                   de_in,
  input  logic [3*DW-1:0]        data_in,
  input  logic [NUM_CH-1:0]      ch_vs,
  input  logic [NUM_CH-1:0]      ch_hs,
  input  logic [NUM_CH-1:0]      ch_de,
  input  logic [NUM_CH*3*DW-1:0] ch_data,
  input  logic [NUM_CH-1:0]      mode_req,
  output logic                   vs_out,
  output logic                   hs_out,
  output logic                   de_out,
  output logic [3*DW-1:0]        data_out,
  output logic [NUM_CH-1:0]      ch_en,
  output logic [NUM_CH-1:0]      mode_active,
  output logic                   switch_pending,
  output logic                   mode_err
);

  localparam int PW = 3 * DW;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] req_q;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [FCNT_W-1:0] mute_end_q, mute_end_d;
  logic              err_q;
  logic [NUM_CH-1:0] ch_en_q;
  logic              sw_pend_q;
  logic              vs_out_q, hs_out_q, de_out_q;
  logic [PW-1:0]     data_out_q;

  logic              frame_tick;
  logic [FCNT_W-1:0] frame_cnt;
  logic              req_valid;
  logic              src_vs, src_hs, src_de;
  logic [PW-1:0]     src_data;

  video_frame_tick u_frame_tick (
    .clk_i        (clk),
    .rst_i        (reset),
    .vs_i         (vs_in),
    .frame_tick_o (frame_tick),
    .frame_cnt_o  (frame_cnt)
  );

  assign req_valid = onehot0(MAX_CH'(mode_req));

  // Pending is only meaningful in WAIT_VS, since an all-zero target (bypass) is valid.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pend_d     = pend_q;
    mute_end_d = mute_end_q;
    case (state_q)
      ST_RUN: begin
        if (req_q != mode_q) begin
          pend_d  = req_q;
          state_d = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (req_q == mode_q) begin
          pend_d  = '0;
          state_d = ST_RUN;
        end else if (req_q != pend_q) begin
          pend_d = req_q;
        end else if (frame_tick) begin
          mode_d     = pend_q;
          pend_d     = '0;
          mute_end_d = frame_cnt + FCNT_W'(MUTE_FRAMES) + FCNT_W'(1);
          state_d    = (MUTE_FRAMES == 0) ? ST_RUN : ST_MUTE;
        end
      end
      ST_MUTE: begin
        pend_d = (req_q != mode_q) ? req_q : '0;
        if (frame_tick && (frame_cnt + FCNT_W'(1) == mute_end_q)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Source follows the next committed mode so a new frame starts cleanly on the new stream.
  always_comb begin
    src_vs   = vs_in;
    src_hs   = hs_in;
    src_de   = de_in;
    src_data = data_in;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mode_d[i]) begin
        src_vs   = ch_vs[i];
        src_hs   = ch_hs[i];
        src_de   = ch_de[i];
        src_data = ch_data[i*PW +: PW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      req_q      <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      mute_end_q <= '0;
      err_q      <= 1'b0;
      ch_en_q    <= '0;
      sw_pend_q  <= 1'b0;
      vs_out_q   <= 1'b0;
      hs_out_q   <= 1'b0;
      de_out_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      req_q      <= req_valid ? mode_req : '0;
      err_q      <= err_q | ~req_valid;
      state_q    <= state_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      mute_end_q <= mute_end_d;
      ch_en_q    <= (state_d == ST_WAIT_VS) ? (mode_d | pend_d) : mode_d;
      sw_pend_q  <= (state_d == ST_WAIT_VS);
      if (init_over) begin
        vs_out_q   <= src_vs;
        hs_out_q   <= src_hs;
        de_out_q   <= src_de;
        data_out_q <= (state_d == ST_MUTE) ? '0 : src_data;
      end else begin
        vs_out_q   <= 1'b0;
        hs_out_q   <= 1'b0;
        de_out_q   <= 1'b0;
        data_out_q <= '0;
      end
    end
  end

  assign vs_out         = vs_out_q;
  assign hs_out         = hs_out_q;
  assign de_out         = de_out_q;
  assign data_out       = data_out_q;
  assign ch_en          = ch_en_q;
  assign mode_active    = mode_q;
  assign switch_pending = sw_pend_q;
  assign mode_err       = err_q;

endmodule

// File: tb/tb_video_effect_switch.sv
// Directed checks of the video effect switch: bypass, switching, retarget, cancel, errors, reset.
module tb_video_effect_switch;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int PW     = 3 * DW;

  logic                 clk;
  logic                 reset;
  logic                 init_over;
  logic                 vs_in, hs_in, de_in;
  logic [PW-1:0]        data_in;
  logic [NUM_CH-1:0]    ch_vs, ch_hs, ch_de;
  logic [NUM_CH*PW-1:0] ch_data;
  logic [NUM_CH-1:0]    mode_req;
  logic                 vs_out, hs_out, de_out;
  logic [PW-1:0]        data_out;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH-1:0]    mode_active;
  logic                 switch_pending;
  logic                 mode_err;

  int checks = 0;
  int errors = 0;

  video_effect_switch #(.NUM_CH(NUM_CH), .DW(DW), .MUTE_FRAMES(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .init_over      (init_over),
    .vs_in          (vs_in),
    .hs_in          (hs_in),
    .de_in          (de_in),
    .data_in        (data_in),
    .ch_vs          (ch_vs),
    .ch_hs          (ch_hs),
    .ch_de          (ch_de),
    .ch_data        (ch_data),
    .mode_req       (mode_req),
    .vs_out         (vs_out),
    .hs_out         (hs_out),
    .de_out         (de_out),
    .data_out       (data_out),
    .ch_en          (ch_en),
    .mode_active    (mode_active),
    .switch_pending (switch_pending),
    .mode_err       (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vs(input logic v);
    vs_in = v;
    ch_vs = {NUM_CH{v}};
  endtask

  initial begin
    reset     = 1'b1;
    init_over = 1'b0;
    set_vs(1'b0);
    hs_in     = 1'b0;
    de_in     = 1'b0;
    data_in   = '0;
    ch_hs     = 4'b0110;
    ch_de     = 4'b1111;
    ch_data   = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    mode_req  = '0;

    step();
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_de", 32'(de_out), 32'h0);
    check("rst_ch_en", 32'(ch_en), 32'h0);
    check("rst_mode", 32'(mode_active), 32'h0);
    check("rst_pend", 32'(switch_pending), 32'h0);
    check("rst_err", 32'(mode_err), 32'h0);

    reset     = 1'b0;
    init_over = 1'b1;
    data_in   = 24'h102030;
    de_in     = 1'b1;
    step();
    check("byp_data", 32'(data_out), 32'h102030);
    check("byp_de", 32'(de_out), 32'h1);
    check("byp_ch_en", 32'(ch_en), 32'h0);

    init_over = 1'b0;
    step();
    check("init_data", 32'(data_out), 32'h0);
    check("init_de", 32'(de_out), 32'h0);
    init_over = 1'b1;
    step();
    check("init_back", 32'(data_out), 32'h102030);

    // Switch bypass -> channel 1
    mode_req = 4'b0010;
    step();
    check("sw1_en_early", 32'(ch_en), 32'h0);
    step();
    check("sw1_en", 32'(ch_en), 32'h2);
    check("sw1_pend", 32'(switch_pending), 32'h1);
    check("sw1_still_byp", 32'(data_out), 32'h102030);
    step();
    check("sw1_wait_byp", 32'(data_out), 32'h102030);
    set_vs(1'b1);
    step();
    check("sw1_commit_mode", 32'(mode_active), 32'h2);
    check("sw1_commit_en", 32'(ch_en), 32'h2);
    check("sw1_commit_pend", 32'(switch_pending), 32'h0);
    check("sw1_mute_data", 32'(data_out), 32'h0);
    check("sw1_vs", 32'(vs_out), 32'h1);
    check("sw1_hs", 32'(hs_out), 32'h1);
    set_vs(1'b0);
    step();
    check("sw1_mute_data2", 32'(data_out), 32'h0);
    check("sw1_de", 32'(de_out), 32'h1);
    set_vs(1'b1);
    step();
    check("sw1_live", 32'(data_out), 32'h222222);
    set_vs(1'b0);

    // Channel 1 -> channel 0
    mode_req = 4'b0001;
    step();
    step();
    check("sw0_en", 32'(ch_en), 32'h3);
    set_vs(1'b1);
    step();
    check("sw0_commit", 32'(mode_active), 32'h1);
    set_vs(1'b0);
    step();
    set_vs(1'b1);
    step();
    check("sw0_live", 32'(data_out), 32'h111111);
    set_vs(1'b0);

    // Pending channel 2, retargeted to channel 3 before vsync
    mode_req = 4'b0100;
    step();
    step();
    check("rt_en_a", 32'(ch_en), 32'h5);
    mode_req = 4'b1000;
    step();
    check("rt_en_hold", 32'(ch_en), 32'h5);
    step();
    check("rt_en_b", 32'(ch_en), 32'h9);
    check("rt_pend", 32'(switch_pending), 32'h1);
    set_vs(1'b1);
    step();
    check("rt_commit_mode", 32'(mode_active), 32'h8);
    check("rt_commit_en", 32'(ch_en), 32'h8);
    check("rt_mute", 32'(data_out), 32'h0);
    set_vs(1'b0);
    step();
    set_vs(1'b1);
    step();
    check("rt_live", 32'(data_out), 32'h444444);
    set_vs(1'b0);

    // Multi-hot request behaves as bypass and latches the error flag
    mode_req = 4'b0110;
    step();
    check("err_set", 32'(mode_err), 32'h1);
    step();
    check("err_en", 32'(ch_en), 32'h8);
    check("err_pend", 32'(switch_pending), 32'h1);
    set_vs(1'b1);
    step();
    check("err_mode", 32'(mode_active), 32'h0);
    check("err_en0", 32'(ch_en), 32'h0);
    check("err_mute", 32'(data_out), 32'h0);
    set_vs(1'b0);
    step();
    set_vs(1'b1);
    step();
    check("err_byp_data", 32'(data_out), 32'h102030);
    check("err_byp_hs", 32'(hs_out), 32'h0);
    set_vs(1'b0);
    mode_req = 4'b0001;
    step();
    check("err_sticky", 32'(mode_err), 32'h1);
    step();
    check("cn_en", 32'(ch_en), 32'h1);
    check("cn_pend", 32'(switch_pending), 32'h1);
    mode_req = 4'b0000;
    step();
    step();
    check("cn_pend0", 32'(switch_pending), 32'h0);
    check("cn_en0", 32'(ch_en), 32'h0);
    check("cn_mode", 32'(mode_active), 32'h0);

    // Request registered in the boundary cycle must wait for the next boundary
    mode_req = 4'b0100;
    step();
    set_vs(1'b1);
    step();
    check("vsr_no_commit", 32'(mode_active), 32'h0);
    check("vsr_pend", 32'(switch_pending), 32'h1);
    check("vsr_en", 32'(ch_en), 32'h4);
    check("vsr_byp", 32'(data_out), 32'h102030);
    set_vs(1'b0);
    step();
    set_vs(1'b1);
    step();
    check("vsr_commit", 32'(mode_active), 32'h4);
    check("vsr_mute", 32'(data_out), 32'h0);
    set_vs(1'b0);

    // Differing request during MUTE is held, not enabled
    mode_req = 4'b0001;
    step();
    step();
    check("mh_en", 32'(ch_en), 32'h4);
    check("mh_pend", 32'(switch_pending), 32'h0);
    check("mh_mute", 32'(data_out), 32'h0);

    // Reset in MUTE abandons the switch
    reset = 1'b1;
    #1;
    check("mr_data", 32'(data_out), 32'h0);
    check("mr_de", 32'(de_out), 32'h0);
    check("mr_en", 32'(ch_en), 32'h0);
    check("mr_mode", 32'(mode_active), 32'h0);
    check("mr_err", 32'(mode_err), 32'h0);
    mode_req = 4'b0000;
    step();
    reset = 1'b0;
    step();
    check("mr_post_mode", 32'(mode_active), 32'h0);
    check("mr_post_en", 32'(ch_en), 32'h0);
    check("mr_post_pend", 32'(switch_pending), 32'h0);
    check("mr_post_data", 32'(data_out), 32'h102030);
    step();
    check("mr_post_run", 32'(switch_pending), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
